ula_muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer that reuses the existing combinational ALU to execute MUL, DIVU and REMU over multiple cycles. It drives the ALU's control and operand inputs, reads back its result, and returns one 32-bit result through a start/busy/done handshake. It sits beside the ALU in the multicycle datapath. The main control unit starts an operation and stalls until `oDone`.

---
 rtl/ula_muldiv_seq.sv | 133 +++++++++++++
 tb/tb_ula_muldiv_seq.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ula_muldiv_seq.sv
// Multi-cycle MUL / DIVU / REMU sequencer that borrows the shared combinational ALU
// for the per-iteration add (shift-add multiply) or subtract (restoring divide).
module ula_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic [1:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oResult,
  output logic [3:0]       oUlaControl,
  output logic [WIDTH-1:0] oUlaA,
  output logic [WIDTH-1:0] oUlaB,
  input  logic [WIDTH-1:0] iUlaResult
);

  localparam int         CNT_W   = $clog2(WIDTH);
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, stateNext;
  logic [1:0]       opReg;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [WIDTH-1:0] rem, quo, div;
  logic [WIDTH:0]   rs;
  logic             isDiv, ge, lastIter;
  logic [WIDTH-1:0] remNext, quoNext;

  // Reserved op code shares the MUL datapath but always reports zero.
  function automatic logic [WIDTH-1:0] selectResult(
    input logic [1:0]       op,
    input logic [WIDTH-1:0] prod,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] r
  );
    case (op)
      OP_MUL:  return prod;
      OP_DIVU: return q;
      OP_REMU: return r;
      default: return '0;
    endcase
  endfunction

  assign isDiv    = (opReg == OP_DIVU) || (opReg == OP_REMU);
  assign lastIter = (cnt == CNT_W'(WIDTH - 1));

  // Unsigned compare is done locally: the ALU's SLT is signed and unusable here.
  // rem never keeps a carry bit, since a set rs[WIDTH] always forces a subtract.
  assign rs      = {rem, quo[WIDTH-1]};
  assign ge      = rs[WIDTH] | (rs[WIDTH-1:0] >= div);
  assign remNext = ge ? iUlaResult : rs[WIDTH-1:0];
  assign quoNext = {quo[WIDTH-2:0], ge};

  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    oBusy       = 1'b0;
    oDone       = 1'b0;
    oUlaControl = ALU_ADD;
    oUlaA       = '0;
    oUlaB       = '0;
    case (state)
      IDLE: if (iStart) stateNext = RUN;
      RUN: begin
        oBusy = 1'b1;
        if (isDiv) begin
          oUlaControl = ALU_SUB;
          oUlaA       = rs[WIDTH-1:0];
          oUlaB       = div;
        end else begin
          oUlaA = acc;
          oUlaB = mplier[0] ? mcand : '0;
        end
        if (lastIter) stateNext = DONE;
      end
      DONE: begin
        oBusy     = 1'b1;
        oDone     = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      opReg   <= '0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      quo     <= '0;
      div     <= '0;
      oResult <= '0;
    end else if (state == IDLE && iStart) begin
      opReg  <= iOp;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= iA;
      mplier <= iB;
      rem    <= '0;
      quo    <= iA;
      div    <= iB;
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      if (isDiv) begin
        rem <= remNext;
        quo <= quoNext;
      end else begin
        acc    <= iUlaResult;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
      if (lastIter) oResult <= selectResult(opReg, iUlaResult, quoNext, remNext);
    end
  end

endmodule

// File: tb/tb_ula_muldiv_seq.sv
// Directed bench for ula_muldiv_seq with a behavioural add/sub ALU closing the loop.
module tb_ula_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;
  logic [3:0]  ulaCtrl;
  logic [31:0] ulaA, ulaB, ulaRes;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign ulaRes = (ulaCtrl == 4'b0010) ? ulaA + ulaB :
                  (ulaCtrl == 4'b0110) ? ulaA - ulaB : 32'h0;

  ula_muldiv_seq #(.WIDTH(32)) dut (
    .iCLK(clk), .iRST(rst), .iStart(start), .iOp(op), .iA(a), .iB(b),
    .oBusy(busy), .oDone(done), .oResult(result),
    .oUlaControl(ulaCtrl), .oUlaA(ulaA), .oUlaB(ulaB), .iUlaResult(ulaRes)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Caller is 1 time unit after an edge; that cycle is cycle 0 (start accepted).
  // Returns 1 time unit into cycle 34.
  task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp, input bit inject);
    int  doneCyc = -1;
    bit  busyOk  = 1'b1;
    bit  subOk   = 1'b1;
    start = 1'b1; op = o; a = x; b = y;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      nextCycle();
      start = 1'b0;
      if (inject && (cyc == 5 || cyc == 33)) begin
        start = 1'b1; op = 2'b00; a = 32'd100; b = 32'd100;
      end
      if (busy !== 1'b1) busyOk = 1'b0;
      if (o == 2'b01 && !done && ulaCtrl !== 4'b0110) subOk = 1'b0;
      if (done === 1'b1) begin
        doneCyc = cyc;
        break;
      end
    end
    check({tag, " doneCycle"}, doneCyc, 32'd33);
    check({tag, " result"}, result, exp);
    check({tag, " busyDuringRun"}, {31'b0, busyOk}, 32'd1);
    if (o == 2'b01) check({tag, " aluSubDuringRun"}, {31'b0, subOk}, 32'd1);
    nextCycle();
    start = 1'b0;
    check({tag, " idleBusy"}, {31'b0, busy}, 32'd0);
    check({tag, " idleDone"}, {31'b0, done}, 32'd0);
    check({tag, " resultHeld"}, result, exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    nextCycle();
    nextCycle();
    rst = 1'b0;
    check("resetBusy", {31'b0, busy}, 32'd0);
    check("resetDone", {31'b0, done}, 32'd0);
    check("resetResult", result, 32'd0);
    check("idleUlaCtrl", {28'b0, ulaCtrl}, 32'h2);
    check("idleUlaA", ulaA, 32'd0);
    check("idleUlaB", ulaB, 32'd0);
    nextCycle();

    runOp("mul7x6", 2'b00, 32'd7, 32'd6, 32'd42, 1'b0);
    runOp("mulWrap", 2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0);
    runOp("divu100by7", 2'b01, 32'd100, 32'd7, 32'd14, 1'b0);
    runOp("remu100by7", 2'b10, 32'd100, 32'd7, 32'd2, 1'b0);
    runOp("divuMaxBy1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0);
    runOp("divuByZero", 2'b01, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b0);
    runOp("remuByZero", 2'b10, 32'h1234, 32'd0, 32'h0000_1234, 1'b0);

    // Reset in RUN cycle 10 must abort silently and clear the held result.
    start = 1'b1; op = 2'b00; a = 32'h10; b = 32'd3;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      nextCycle();
      start = 1'b0;
    end
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    check("rstMidRun busy", {31'b0, busy}, 32'd0);
    check("rstMidRun done", {31'b0, done}, 32'd0);
    check("rstMidRun result", result, 32'd0);
    nextCycle();
    runOp("mulAfterReset", 2'b00, 32'h10, 32'd3, 32'h30, 1'b0);

    runOp("mulStartIgnored", 2'b00, 32'd7, 32'd6, 32'd42, 1'b1);
    nextCycle();
    check("noRestartBusy", {31'b0, busy}, 32'd0);

    runOp("opReserved", 2'b11, 32'd5, 32'd3, 32'd0, 1'b0);
    check("finalIdleUlaCtrl", {28'b0, ulaCtrl}, 32'h2);
    check("finalIdleUlaA", ulaA, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
